// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: state and opcode
// encodings, ALU-decoder operation codes and the packed control word.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{default: '0};

    function automatic logic is_legal_op(input logic [5:0] op);
        logic legal_s;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal_s = 1'b1;
            default:                                       legal_s = 1'b0;
        endcase
        return legal_s;
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// State-to-control-word decode. FETCH reports irwrite/pcwrite unconditionally;
// the FSM gates them with the memory handshake.
module mc_outdec
    import mips_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Moore control word per state; unlisted fields stay at zero
    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            S_FETCH: begin
                ctrl.irwrite = 1'b1;
                ctrl.pcwrite = 1'b1;
                ctrl.alusrcb = 2'b01;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.pcsrc   = 2'b00;
            end
            S_DECODE: begin
                ctrl.alusrcb = 2'b11;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: ctrl.iord = 1'b1;
            S_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_ADDIWB: ctrl.regwrite = 1'b1;
            S_BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = 2'b01;
                ctrl.branch  = 1'b1;
            end
            S_JEX: begin
                ctrl.pcsrc   = 2'b10;
                ctrl.pcwrite = 1'b1;
            end
            default: ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: state register, next-state logic and the
// handshake/zero gating of the decoded control word.
module mc_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       illegal_op
);

    state_t state_r;
    state_t next_s;
    ctrl_t  ctrl_s;
    logic   fetch_gate_s;
    logic   pcwrite_s;

    mc_outdec u_outdec (
        .state (state_r),
        .ctrl  (ctrl_s)
    );

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; memory states hold until mem_ready
    always_comb begin
        next_s = S_FETCH;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) next_s = S_DECODE;
                else           next_s = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_s = S_MEMADR;
                    OP_RTYPE:     next_s = S_RTYPEEX;
                    OP_BEQ:       next_s = S_BEQEX;
                    OP_ADDI:      next_s = S_ADDIEX;
                    OP_J:         next_s = S_JEX;
                    default:      next_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_SW) next_s = S_MEMWR;
                else             next_s = S_MEMRD;
            end
            S_MEMRD: begin
                if (mem_ready) next_s = S_MEMWB;
                else           next_s = S_MEMRD;
            end
            S_MEMWR: begin
                if (mem_ready) next_s = S_FETCH;
                else           next_s = S_MEMWR;
            end
            S_RTYPEEX: next_s = S_RTYPEWB;
            S_ADDIEX:  next_s = S_ADDIWB;
            default:   next_s = S_FETCH;
        endcase
    end

    // FETCH strobes only fire on a completed read and never while in reset
    assign fetch_gate_s = (state_r != S_FETCH) | (mem_ready & ~reset);
    assign pcwrite_s    = ctrl_s.pcwrite & fetch_gate_s;

    assign iord       = ctrl_s.iord;
    assign memwrite   = ctrl_s.memwrite;
    assign irwrite    = ctrl_s.irwrite & fetch_gate_s;
    assign regdst     = ctrl_s.regdst;
    assign memtoreg   = ctrl_s.memtoreg;
    assign regwrite   = ctrl_s.regwrite;
    assign alusrca    = ctrl_s.alusrca;
    assign alusrcb    = ctrl_s.alusrcb;
    assign aluop      = ctrl_s.aluop;
    assign pcsrc      = ctrl_s.pcsrc;
    assign pcen       = pcwrite_s | (ctrl_s.branch & zero);
    assign illegal_op = (state_r == S_DECODE) & ~is_legal_op(op);

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller; expected control words are
// hand-written constants packed as {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,aluop,pcsrc,pcen,illegal_op}.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       pcen, illegal_op;

    int total;
    int bad;

    localparam logic [14:0] E_FETCH_RDY  = 15'b001000001000010;
    localparam logic [14:0] E_FETCH_WAIT = 15'b000000001000000;
    localparam logic [14:0] E_DECODE     = 15'b000000011000000;
    localparam logic [14:0] E_ILLEGAL    = 15'b000000011000001;
    localparam logic [14:0] E_MEMADR     = 15'b000000110000000;
    localparam logic [14:0] E_MEMRD      = 15'b100000000000000;
    localparam logic [14:0] E_MEMWR      = 15'b110000000000000;
    localparam logic [14:0] E_MEMWB      = 15'b000011000000000;
    localparam logic [14:0] E_RTYPEEX    = 15'b000000100100000;
    localparam logic [14:0] E_RTYPEWB    = 15'b000101000000000;
    localparam logic [14:0] E_ADDIWB     = 15'b000001000000000;
    localparam logic [14:0] E_BEQ_Z0     = 15'b000000100010100;
    localparam logic [14:0] E_BEQ_Z1     = 15'b000000100010110;
    localparam logic [14:0] E_JEX        = 15'b000000000001010;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .aluop      (aluop),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] obs();
        return {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, aluop, pcsrc, pcen, illegal_op};
    endfunction

    function automatic logic [3:0] cur_state();
        logic [3:0] s;
        s = dut.state_r;
        return s;
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven
    task automatic cyc(input string tag, input logic [14:0] ew, input logic [3:0] es);
        #1;
        chk_eq({tag, "_st"}, {28'd0, cur_state()}, {28'd0, es});
        chk_eq(tag, {17'd0, obs()}, {17'd0, ew});
        @(negedge clk);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        op        = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b0;

        @(negedge clk);
        #1;
        chk_eq("rst_st", {28'd0, cur_state()}, 32'd0);
        chk_eq("rst_out", {17'd0, obs()}, {17'd0, E_FETCH_WAIT});
        mem_ready = 1'b1;
        #1;
        chk_eq("rst_ready_out", {17'd0, obs()}, {17'd0, E_FETCH_WAIT});
        @(negedge clk);

        // LW with one stall cycle in FETCH and one in MEMRD
        reset = 1'b0; op = 6'b100011; mem_ready = 1'b0;
        cyc("lw_fwait", E_FETCH_WAIT, 4'd0);
        mem_ready = 1'b1;
        cyc("lw_fetch", E_FETCH_RDY, 4'd0);
        cyc("lw_dec", E_DECODE, 4'd1);
        cyc("lw_adr", E_MEMADR, 4'd2);
        mem_ready = 1'b0;
        cyc("lw_rdwait", E_MEMRD, 4'd3);
        mem_ready = 1'b1;
        cyc("lw_rd", E_MEMRD, 4'd3);
        cyc("lw_wb", E_MEMWB, 4'd4);

        // SW with three wait cycles in MEMWR
        op = 6'b101011;
        cyc("sw_fetch", E_FETCH_RDY, 4'd0);
        mem_ready = 1'b0;
        cyc("sw_dec_ignore", E_DECODE, 4'd1);
        cyc("sw_adr", E_MEMADR, 4'd2);
        cyc("sw_wr0", E_MEMWR, 4'd5);
        cyc("sw_wr1", E_MEMWR, 4'd5);
        cyc("sw_wr2", E_MEMWR, 4'd5);
        mem_ready = 1'b1;
        cyc("sw_wr3", E_MEMWR, 4'd5);

        // BEQ taken then not taken
        op = 6'b000100; zero = 1'b1;
        cyc("beq1_fetch", E_FETCH_RDY, 4'd0);
        cyc("beq1_dec", E_DECODE, 4'd1);
        cyc("beq1_ex", E_BEQ_Z1, 4'd8);
        zero = 1'b0;
        cyc("beq0_fetch", E_FETCH_RDY, 4'd0);
        cyc("beq0_dec", E_DECODE, 4'd1);
        cyc("beq0_ex", E_BEQ_Z0, 4'd8);

        // R-type then ADDI back to back
        op = 6'b000000;
        cyc("r_fetch", E_FETCH_RDY, 4'd0);
        cyc("r_dec", E_DECODE, 4'd1);
        cyc("r_ex", E_RTYPEEX, 4'd6);
        cyc("r_wb", E_RTYPEWB, 4'd7);
        op = 6'b001000;
        cyc("addi_fetch", E_FETCH_RDY, 4'd0);
        cyc("addi_dec", E_DECODE, 4'd1);
        cyc("addi_ex", E_MEMADR, 4'd9);
        cyc("addi_wb", E_ADDIWB, 4'd10);

        // Jump
        op = 6'b000010;
        cyc("j_fetch", E_FETCH_RDY, 4'd0);
        cyc("j_dec", E_DECODE, 4'd1);
        cyc("j_ex", E_JEX, 4'd11);

        // Unsupported opcode
        op = 6'b111111;
        cyc("ill_fetch", E_FETCH_RDY, 4'd0);
        cyc("ill_dec", E_ILLEGAL, 4'd1);

        // Reset in the middle of a stalled store
        op = 6'b101011;
        cyc("rsw_fetch", E_FETCH_RDY, 4'd0);
        cyc("rsw_dec", E_DECODE, 4'd1);
        mem_ready = 1'b0;
        cyc("rsw_adr", E_MEMADR, 4'd2);
        #1;
        chk_eq("rsw_wr", {17'd0, obs()}, {17'd0, E_MEMWR});
        reset = 1'b1;
        #1;
        chk_eq("rsw_async_memwrite", {31'd0, memwrite}, 32'd0);
        chk_eq("rsw_async_st", {28'd0, cur_state()}, 32'd0);
        @(posedge clk);
        #1;
        chk_eq("rsw_edge_st", {28'd0, cur_state()}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc("post_rst_wait", E_FETCH_WAIT, 4'd0);
        mem_ready = 1'b1;
        cyc("post_rst_fetch", E_FETCH_RDY, 4'd0);
        cyc("post_rst_dec", E_DECODE, 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
